// File: rtl/clink_rx_parser_if.sv
// Signal bundle between the C-link rx parser, the rx byte buffer and the application.
// Handshake: every strobe here is a one-cycle pulse with no back-pressure; data is valid in the pulse cycle.
interface clink_rx_parser_if;
  logic [3:0]  station_id;
  logic [3:0]  slot_id;
  logic        rx_done;
  logic [10:0] rx_data_len;
  logic        rx_buf_rden;
  logic [10:0] rx_buf_raddr;
  logic [7:0]  rx_buf_rdata;
  logic        ch1_rxbuf_wren;
  logic [9:0]  ch1_rxbuf_waddr;
  logic [7:0]  ch1_rxbuf_wdata;
  logic        frame_valid;
  logic [23:0] rx_sa;
  logic [7:0]  rx_sn;
  logic [15:0] rx_tn;
  logic [15:0] rx_pn;
  logic        len_err;
  logic        pn_err;
  logic        sn_err;
  logic        overrun;
  logic        busy;
  logic [1:0]  state_dbg;

  // master is the parser itself; slave is the buffer/application side.
  modport master (
    input  station_id, slot_id, rx_done, rx_data_len, rx_buf_rdata,
    output rx_buf_rden, rx_buf_raddr, ch1_rxbuf_wren, ch1_rxbuf_waddr, ch1_rxbuf_wdata,
    output frame_valid, rx_sa, rx_sn, rx_tn, rx_pn,
    output len_err, pn_err, sn_err, overrun, busy, state_dbg
  );

  modport slave (
    output station_id, slot_id, rx_done, rx_data_len, rx_buf_rdata,
    input  rx_buf_rden, rx_buf_raddr, ch1_rxbuf_wren, ch1_rxbuf_waddr, ch1_rxbuf_wdata,
    input  frame_valid, rx_sa, rx_sn, rx_tn, rx_pn,
    input  len_err, pn_err, sn_err, overrun, busy, state_dbg
  );
endinterface

// File: rtl/clink_rx_parser.sv
// C-link receive framer: reads a completed frame from the rx buffer, parses the header,
// filters on destination address and copies the payload into the channel-1 rx buffer.
module clink_rx_parser (
  input logic                 clk,
  input logic                 reset,
  clink_rx_parser_if.master   bus
);
  localparam int          HDR_LEN   = 11;
  localparam int          PAY_LEN   = 1024;
  localparam logic [23:0] BCAST_DA  = 24'hFFFFFF;
  localparam logic [10:0] FRAME_LEN = 11'(HDR_LEN + PAY_LEN);
  localparam logic [10:0] LAST_ADDR = FRAME_LEN - 11'd1;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAY, S_CHECK} state_t;

  state_t      r_state;
  logic [23:0] r_own;
  logic [63:0] r_hdr;
  logic        r_vld_d;
  logic [10:0] r_addr_d;
  logic [9:0]  r_wptr;
  logic        r_sn_seen;
  logic [7:0]  r_last_sn;
  logic        r_rden;
  logic [10:0] r_raddr;
  logic        r_wren;
  logic [9:0]  r_waddr;
  logic [7:0]  r_wdata;
  logic        r_frame_valid;
  logic [23:0] r_sa;
  logic [7:0]  r_sn;
  logic [15:0] r_tn;
  logic [15:0] r_pn;
  logic        r_len_err;
  logic        r_pn_err;
  logic        r_sn_err;
  logic        r_overrun;
  logic        r_busy;

  // DA completes when its third byte is on the read bus; compare before it is shifted in.
  logic [23:0] w_da;
  logic        w_da_hit;
  assign w_da     = {r_hdr[15:0], bus.rx_buf_rdata};
  assign w_da_hit = (w_da == r_own) || (w_da == BCAST_DA);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_own         <= '0;
      r_hdr         <= '0;
      r_vld_d       <= 1'b0;
      r_addr_d      <= '0;
      r_wptr        <= '0;
      r_sn_seen     <= 1'b0;
      r_last_sn     <= '0;
      r_rden        <= 1'b0;
      r_raddr       <= '0;
      r_wren        <= 1'b0;
      r_waddr       <= '0;
      r_wdata       <= '0;
      r_frame_valid <= 1'b0;
      r_sa          <= '0;
      r_sn          <= '0;
      r_tn          <= '0;
      r_pn          <= '0;
      r_len_err     <= 1'b0;
      r_pn_err      <= 1'b0;
      r_sn_err      <= 1'b0;
      r_overrun     <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_wren        <= 1'b0;
      r_frame_valid <= 1'b0;
      r_len_err     <= 1'b0;
      r_pn_err      <= 1'b0;
      r_sn_err      <= 1'b0;
      r_overrun     <= 1'b0;
      // Read data trails the address by one cycle; track which address it belongs to.
      r_vld_d       <= r_rden;
      r_addr_d      <= r_raddr;

      if (r_rden) begin
        if (r_raddr == LAST_ADDR) r_rden  <= 1'b0;
        else                      r_raddr <= r_raddr + 11'd1;
      end

      if (bus.rx_done && (r_state != S_IDLE)) r_overrun <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (bus.rx_done) begin
            r_own <= {8'h00, 4'h0, bus.station_id, 4'h0, bus.slot_id};
            if (bus.rx_data_len != FRAME_LEN) begin
              r_len_err <= 1'b1;
            end else begin
              r_state <= S_HDR;
              r_busy  <= 1'b1;
              r_rden  <= 1'b1;
              r_raddr <= '0;
              r_wptr  <= '0;
            end
          end
        end
        S_HDR: begin
          if (r_vld_d) begin
            r_hdr <= {r_hdr[55:0], bus.rx_buf_rdata};
            if ((r_addr_d == 11'd2) && !w_da_hit) begin
              r_rden  <= 1'b0;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else if (r_addr_d == 11'(HDR_LEN - 1)) begin
              r_state <= S_PAY;
            end
          end
        end
        S_PAY: begin
          if (r_vld_d) begin
            r_wren  <= 1'b1;
            r_waddr <= r_wptr;
            r_wdata <= bus.rx_buf_rdata;
            r_wptr  <= r_wptr + 10'd1;
            if (r_addr_d == LAST_ADDR) r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          // After 11 shifts the register holds SA, SN, TN, PN (DA has been shifted out).
          r_sa          <= r_hdr[63:40];
          r_sn          <= r_hdr[39:32];
          r_tn          <= r_hdr[31:16];
          r_pn          <= r_hdr[15:0];
          r_frame_valid <= 1'b1;
          r_pn_err      <= (r_hdr[15:0] != 16'd1) && (r_hdr[15:0] != 16'd2);
          r_sn_err      <= r_sn_seen && (r_hdr[39:32] != (r_last_sn + 8'd1));
          r_sn_seen     <= 1'b1;
          r_last_sn     <= r_hdr[39:32];
          r_busy        <= 1'b0;
          r_state       <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.rx_buf_rden     = r_rden;
  assign bus.rx_buf_raddr    = r_raddr;
  assign bus.ch1_rxbuf_wren  = r_wren;
  assign bus.ch1_rxbuf_waddr = r_waddr;
  assign bus.ch1_rxbuf_wdata = r_wdata;
  assign bus.frame_valid     = r_frame_valid;
  assign bus.rx_sa           = r_sa;
  assign bus.rx_sn           = r_sn;
  assign bus.rx_tn           = r_tn;
  assign bus.rx_pn           = r_pn;
  assign bus.len_err         = r_len_err;
  assign bus.pn_err          = r_pn_err;
  assign bus.sn_err          = r_sn_err;
  assign bus.overrun         = r_overrun;
  assign bus.busy            = r_busy;
  assign bus.state_dbg       = r_state;
endmodule

// File: tb/tb_clink_rx_parser.sv
// Bench for clink_rx_parser: directed frames, a byte-buffer model and a queue-based scoreboard.
module tb_clink_rx_parser;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  clink_rx_parser_if bus();
  clink_rx_parser dut (.clk(clk), .reset(reset), .bus(bus));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous rx byte buffer: data one cycle after the address.
  logic [7:0] mem [0:2047];
  always @(posedge clk) if (bus.rx_buf_rden) bus.rx_buf_rdata <= mem[bus.rx_buf_raddr];

  typedef struct {
    logic [23:0] sa;
    logic [7:0]  sn;
    logic [15:0] tn;
    logic [15:0] pn;
    logic        pn_err;
    logic        sn_err;
  } fr_t;

  logic [17:0] exp_q[$];
  fr_t         fr_q[$];
  int          exp_len_cnt = 0;
  int          exp_ovr_cnt = 0;
  int          frame_t0 = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor
  logic [17:0] mon_e;
  fr_t         mon_f;
  always @(negedge clk) begin
    if (reset) begin
      if (bus.ch1_rxbuf_wren) begin
        if (exp_q.size() == 0) check("unexpected_write", {bus.ch1_rxbuf_waddr, bus.ch1_rxbuf_wdata}, 18'h3ffff);
        else begin
          mon_e = exp_q.pop_front();
          check("ch1_write", {bus.ch1_rxbuf_waddr, bus.ch1_rxbuf_wdata}, mon_e);
        end
      end
      if (bus.frame_valid) begin
        if (fr_q.size() == 0) check("unexpected_frame_valid", 1, 0);
        else begin
          mon_f = fr_q.pop_front();
          check("fv_latency", cyc - frame_t0, 1038);
          check("rx_sa", bus.rx_sa, mon_f.sa);
          check("rx_sn", bus.rx_sn, mon_f.sn);
          check("rx_tn", bus.rx_tn, mon_f.tn);
          check("rx_pn", bus.rx_pn, mon_f.pn);
          check("pn_err", bus.pn_err, mon_f.pn_err);
          check("sn_err", bus.sn_err, mon_f.sn_err);
          check("writes_done_at_fv", exp_q.size(), 0);
        end
      end else if (bus.pn_err || bus.sn_err) begin
        check("stray_err_pulse", {bus.pn_err, bus.sn_err}, 0);
      end
      if (bus.len_err) begin
        check("len_err_expected", exp_len_cnt > 0, 1);
        if (exp_len_cnt > 0) exp_len_cnt--;
      end
      if (bus.overrun) begin
        check("overrun_expected", exp_ovr_cnt > 0, 1);
        if (exp_ovr_cnt > 0) exp_ovr_cnt--;
      end
    end
  end

  // Drivers
  task automatic build(input logic [23:0] da, input logic [23:0] sa, input logic [7:0] sn,
                       input logic [15:0] tn, input logic [15:0] pn, input logic [7:0] seed,
                       input bit accept, input bit pn_e, input bit sn_e);
    logic [7:0] b;
    fr_t f;
    mem[0] = da[23:16]; mem[1] = da[15:8]; mem[2] = da[7:0];
    mem[3] = sa[23:16]; mem[4] = sa[15:8]; mem[5] = sa[7:0];
    mem[6] = sn;
    mem[7] = tn[15:8];  mem[8] = tn[7:0];
    mem[9] = pn[15:8];  mem[10] = pn[7:0];
    for (int i = 0; i < 1024; i++) begin
      b = 8'(i) + seed;
      mem[11 + i] = b;
      if (accept) exp_q.push_back({10'(i), b});
    end
    if (accept) begin
      f.sa = sa; f.sn = sn; f.tn = tn; f.pn = pn; f.pn_err = pn_e; f.sn_err = sn_e;
      fr_q.push_back(f);
    end
  endtask

  task automatic pulse_done(input logic [10:0] len, input bit is_frame);
    @(negedge clk);
    bus.rx_data_len = len;
    bus.rx_done = 1'b1;
    if (is_frame) frame_t0 = cyc;
    @(negedge clk);
    bus.rx_done = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 1300 && !done; i++) begin
      if (fr_q.size() == 0 && exp_q.size() == 0 && !bus.busy) done = 1'b1;
      else @(negedge clk);
    end
    check(name, done, 1);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_rden"}, bus.rx_buf_rden, 0);
    check({name, "_wren"}, bus.ch1_rxbuf_wren, 0);
    check({name, "_waddr"}, bus.ch1_rxbuf_waddr, 0);
    check({name, "_fv"}, bus.frame_valid, 0);
    check({name, "_hdr"}, {bus.rx_sa, bus.rx_sn, bus.rx_tn}, 0);
    check({name, "_pn"}, bus.rx_pn, 0);
    check({name, "_flags"}, {bus.len_err, bus.pn_err, bus.sn_err, bus.overrun, bus.busy}, 0);
    check({name, "_state"}, bus.state_dbg, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit any_rden;
    reset = 1'b0;
    bus.rx_done = 1'b0;
    bus.rx_data_len = '0;
    bus.station_id = 4'd3;
    bus.slot_id = 4'd5;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Own address, first frame: no sn check yet
    build(24'h000305, 24'h123456, 8'd0, 16'd2, 16'd1, 8'd0, 1, 0, 0);
    pulse_done(11'd1035, 1);
    wait_idle("idle_a");

    build(24'h000305, 24'hABCDEF, 8'd1, 16'h1234, 16'd2, 8'd7, 1, 0, 0);
    pulse_done(11'd1035, 1);
    wait_idle("idle_b");

    build(24'h000305, 24'h010203, 8'd3, 16'hBEEF, 16'd1, 8'd33, 1, 0, 1);
    pulse_done(11'd1035, 1);
    wait_idle("idle_c");

    build(24'h000305, 24'h0A0B0C, 8'd255, 16'd9, 16'd2, 8'd90, 1, 0, 1);
    pulse_done(11'd1035, 1);
    wait_idle("idle_d");

    // 255 -> 0 wraps cleanly
    build(24'h000305, 24'h777777, 8'd0, 16'hFFFF, 16'd1, 8'd200, 1, 0, 0);
    pulse_done(11'd1035, 1);
    wait_idle("idle_e");

    // Wrong slot: silent discard
    build(24'h000306, 24'h999999, 8'd1, 16'd5, 16'd1, 8'd1, 0, 0, 0);
    pulse_done(11'd1035, 1);
    repeat (4) @(negedge clk);
    check("discard_busy", bus.busy, 0);
    check("discard_rden", bus.rx_buf_rden, 0);
    repeat (20) @(negedge clk);
    check("discard_hdr_hold", {bus.rx_sa, bus.rx_sn}, {24'h777777, 8'd0});

    // Broadcast DA accepted
    build(24'hFFFFFF, 24'h999999, 8'd1, 16'd5, 16'd1, 8'd1, 1, 0, 0);
    pulse_done(11'd1035, 1);
    wait_idle("idle_bcast");

    // Short length: len_err, nothing read
    exp_len_cnt++;
    pulse_done(11'd1034, 0);
    any_rden = 1'b0;
    for (int i = 0; i < 12; i++) begin
      any_rden |= bus.rx_buf_rden | bus.busy;
      @(negedge clk);
    end
    check("len_no_read", any_rden, 0);
    check("len_err_seen", exp_len_cnt, 0);

    // PN = 3
    build(24'h000305, 24'h424242, 8'd2, 16'd100, 16'd3, 8'd11, 1, 1, 0);
    pulse_done(11'd1035, 1);
    wait_idle("idle_pn");

    // Overrun at cycle 500
    build(24'h000305, 24'h313131, 8'd3, 16'd200, 16'd1, 8'd55, 1, 0, 0);
    pulse_done(11'd1035, 1);
    while (cyc < frame_t0 + 499) @(negedge clk);
    exp_ovr_cnt++;
    pulse_done(11'd1035, 0);
    wait_idle("idle_ovr");
    check("overrun_seen", exp_ovr_cnt, 0);

    // Reset at cycle 300 of a frame
    build(24'h000305, 24'h505050, 8'd4, 16'd1, 16'd1, 8'd66, 1, 0, 0);
    pulse_done(11'd1035, 1);
    while (cyc < frame_t0 + 299) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check_all_zero("abort");
    check("abort_writes_left", exp_q.size(), 738);
    exp_q.delete();
    fr_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // sn_seen cleared by reset: any SN is clean
    build(24'h000305, 24'h606060, 8'd7, 16'd3, 16'd2, 8'd123, 1, 0, 0);
    pulse_done(11'd1035, 1);
    wait_idle("idle_post_reset");
    repeat (5) @(negedge clk);

    check("final_write_q", exp_q.size(), 0);
    check("final_frame_q", fr_q.size(), 0);
    check("final_len_ovr", {exp_len_cnt[7:0], exp_ovr_cnt[7:0]}, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
